// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: scope acquisition sequencer.
// Pre-trigger fill, trigger search, post-trigger fill into circular RAM.
module scope_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] pretrig,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT,
    S_POST,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              triggered_q, triggered_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;

  logic              accept;
  logic              rise;
  logic              fall;
  logic              hit;
  logic [ADDR_W:0]   post_init;

  // Trigger qualification on the incoming sample.
  always_comb begin
    accept = sample_valid &&
             ((state_q == S_PREFILL) ||
              (state_q == S_WAIT) ||
              (state_q == S_POST));
    rise = prev_valid_q && (prev_q < trig_level) &&
           (sample_in >= trig_level);
    fall = prev_valid_q && (prev_q >= trig_level) &&
           (sample_in < trig_level);
    hit  = force_trig || (trig_edge ? fall : rise);
    post_init = (ADDR_W+1)'(DEPTH - 1) - {1'b0, pretrig_q};
  end

  // Next-state, write strobe and capture bookkeeping.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pretrig_d    = pretrig_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    triggered_d  = triggered_q;
    trig_addr_d  = trig_addr_q;
    if (abort) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
    end else begin
      if (accept) begin
        wr_en_d      = 1'b1;
        wr_addr_d    = addr_q;
        wr_data_d    = sample_in;
        addr_d       = addr_q + 1'b1;
        prev_d       = sample_in;
        prev_valid_d = 1'b1;
      end
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            addr_d       = '0;
            pretrig_d    = pretrig;
            pre_cnt_d    = '0;
            prev_valid_d = 1'b0;
            triggered_d  = 1'b0;
            state_d = (pretrig == '0) ? S_WAIT : S_PREFILL;
          end
        end
        S_PREFILL: begin
          if (accept) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
            if (pre_cnt_d == pretrig_q) state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (accept && hit) begin
            trig_addr_d = addr_q;
            triggered_d = 1'b1;
            post_cnt_d  = post_init;
            state_d = (post_init == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (accept) begin
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == 1) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      pretrig_q    <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      triggered_q  <= 1'b0;
      trig_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pretrig_q    <= pretrig_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      triggered_q  <= triggered_d;
      trig_addr_q  <= trig_addr_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign triggered = triggered_q;
  assign trig_addr = trig_addr_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_PREFILL) ||
                     (state_q == S_WAIT) ||
                     (state_q == S_POST);

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// tb_scope_capture_ctrl: directed bench for scope_capture_ctrl.
// ADDR_W=4 (DEPTH=16), DATA_W=8.
module tb_scope_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic       force_trig = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic [7:0] trig_level = 8'h80;
  logic       trig_edge = 1'b0;
  logic [3:0] pretrig = 4'd0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       triggered;
  logic       done;
  logic [3:0] trig_addr;

  int nvec = 0;
  int nerr = 0;

  int         wcount = 0;
  logic [3:0] last_addr = 4'd0;

  scope_capture_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .abort(abort),
    .force_trig(force_trig),
    .sample_valid(sample_valid),
    .sample_in(sample_in),
    .trig_level(trig_level),
    .trig_edge(trig_edge),
    .pretrig(pretrig),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .triggered(triggered),
    .done(done),
    .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  // Write log, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wcount = wcount + 1;
      last_addr = wr_addr;
    end
  end

  task automatic send(input logic [7:0] d, input logic f);
    @(posedge clk);
    @(posedge clk); #1;
    sample_in = d;
    force_trig = f;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    force_trig = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic do_arm(input logic [3:0] p, input logic ab);
    @(posedge clk); #1;
    pretrig = p;
    arm = 1'b1;
    abort = ab;
    @(posedge clk); #1;
    arm = 1'b0;
    abort = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset;
    #3;
    nvec++;
    if ({wr_en, wr_addr, wr_data, busy, triggered, done, trig_addr}
        !== 21'd0) begin
      nerr++;
      $display("FAIL reset_outs got %0h want 0",
        {wr_en, wr_addr, wr_data, busy, triggered, done, trig_addr});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rising;
    int base;
    base = wcount;
    trig_edge = 1'b0;
    trig_level = 8'h80;
    do_arm(4'd4, 1'b0);
    for (int k = 0; k < 8; k++) send(8'(k * 16), 1'b0);
    nvec++;
    if (triggered !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL rise_pre got trig=%0b busy=%0b want 0/1",
        triggered, busy);
    end
    send(8'h80, 1'b0);
    nvec++;
    if (triggered !== 1'b1 || trig_addr !== 4'd8) begin
      nerr++;
      $display("FAIL rise_trig got trig=%0b addr=%0d want 1/8",
        triggered, trig_addr);
    end
    nvec++;
    if (wr_addr !== 4'd8 || wr_data !== 8'h80) begin
      nerr++;
      $display("FAIL rise_wr got %0d/%0h want 8/80", wr_addr, wr_data);
    end
    for (int k = 9; k < 20; k++) send(8'(k * 16), 1'b0);
    nvec++;
    if (wcount - base !== 20 || last_addr !== 4'd3) begin
      nerr++;
      $display("FAIL rise_count got %0d@%0d want 20@3",
        wcount - base, last_addr);
    end
    nvec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rise_done got done=%0b busy=%0b want 1/0",
        done, busy);
    end
    send(8'h00, 1'b0);
    send(8'hff, 1'b1);
    nvec++;
    if (wcount - base !== 20 || done !== 1'b1) begin
      nerr++;
      $display("FAIL rise_hold got %0d done=%0b want 20/1",
        wcount - base, done);
    end
  endtask

  task automatic test_falling;
    int base;
    base = wcount;
    trig_edge = 1'b1;
    trig_level = 8'h80;
    do_arm(4'd0, 1'b0);
    send(8'h90, 1'b0);
    nvec++;
    if (triggered !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL fall_first got trig=%0b busy=%0b want 0/1",
        triggered, busy);
    end
    send(8'h70, 1'b0);
    nvec++;
    if (triggered !== 1'b1 || trig_addr !== 4'd1) begin
      nerr++;
      $display("FAIL fall_trig got trig=%0b addr=%0d want 1/1",
        triggered, trig_addr);
    end
    for (int k = 0; k < 15; k++) send(8'h50, 1'b0);
    nvec++;
    if (wcount - base !== 17 || last_addr !== 4'd0 || done !== 1'b1) begin
      nerr++;
      $display("FAIL fall_end got %0d@%0d done=%0b want 17@0/1",
        wcount - base, last_addr, done);
    end
    trig_edge = 1'b0;
  endtask

  task automatic test_wait_wrap;
    int base;
    base = wcount;
    do_arm(4'd2, 1'b0);
    for (int k = 0; k < 42; k++) send(8'h10, 1'b0);
    nvec++;
    if (triggered !== 1'b0 || wcount - base !== 42 ||
        last_addr !== 4'd9) begin
      nerr++;
      $display("FAIL wrap_wait got trig=%0b %0d@%0d want 0 42@9",
        triggered, wcount - base, last_addr);
    end
    send(8'hff, 1'b0);
    nvec++;
    if (triggered !== 1'b1 || trig_addr !== 4'd10) begin
      nerr++;
      $display("FAIL wrap_trig got trig=%0b addr=%0d want 1/10",
        triggered, trig_addr);
    end
    for (int k = 0; k < 13; k++) send(8'hff, 1'b0);
    nvec++;
    if (wcount - base !== 56 || last_addr !== 4'd7 || done !== 1'b1) begin
      nerr++;
      $display("FAIL wrap_end got %0d@%0d done=%0b want 56@7/1",
        wcount - base, last_addr, done);
    end
  endtask

  task automatic test_force;
    int base;
    base = wcount;
    do_arm(4'd2, 1'b0);
    send(8'h90, 1'b1);
    send(8'h90, 1'b1);
    nvec++;
    if (triggered !== 1'b0) begin
      nerr++;
      $display("FAIL force_prefill got trig=%0b want 0", triggered);
    end
    send(8'h10, 1'b0);
    nvec++;
    if (triggered !== 1'b0) begin
      nerr++;
      $display("FAIL force_notrig got trig=%0b want 0", triggered);
    end
    send(8'ha0, 1'b1);
    nvec++;
    if (triggered !== 1'b1 || trig_addr !== 4'd3) begin
      nerr++;
      $display("FAIL force_trig got trig=%0b addr=%0d want 1/3",
        triggered, trig_addr);
    end
    for (int k = 0; k < 12; k++) send(8'h20, 1'b0);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL force_early got done=%0b busy=%0b want 0/1",
        done, busy);
    end
    send(8'h20, 1'b0);
    nvec++;
    if (wcount - base !== 17 || last_addr !== 4'd0 || done !== 1'b1) begin
      nerr++;
      $display("FAIL force_end got %0d@%0d done=%0b want 17@0/1",
        wcount - base, last_addr, done);
    end
  endtask

  task automatic test_pretrig_max;
    int base;
    base = wcount;
    do_arm(4'd15, 1'b0);
    for (int k = 0; k < 15; k++) send(8'h00, 1'b0);
    nvec++;
    if (triggered !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL max_pre got trig=%0b done=%0b want 0/0",
        triggered, done);
    end
    send(8'hff, 1'b0);
    nvec++;
    if (done !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 4'd15 ||
        trig_addr !== 4'd15) begin
      nerr++;
      $display("FAIL max_done got d=%0b we=%0b wa=%0d ta=%0d want 1/1/15/15",
        done, wr_en, wr_addr, trig_addr);
    end
    nvec++;
    if (wcount - base !== 16 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL max_count got %0d busy=%0b want 16/0",
        wcount - base, busy);
    end
  endtask

  task automatic test_control;
    int base;
    do_arm(4'd0, 1'b0);
    send(8'h00, 1'b1);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    do_arm(4'd5, 1'b0);
    nvec++;
    if (busy !== 1'b1 || triggered !== 1'b1) begin
      nerr++;
      $display("FAIL arm_post got busy=%0b trig=%0b want 1/1",
        busy, triggered);
    end
    send(8'h00, 1'b0);
    nvec++;
    if (wr_addr !== 4'd3) begin
      nerr++;
      $display("FAIL arm_post_addr got %0d want 3", wr_addr);
    end
    do_arm(4'd0, 1'b1);
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || triggered !== 1'b0) begin
      nerr++;
      $display("FAIL abort_arm got b=%0b d=%0b t=%0b want 0/0/0",
        busy, done, triggered);
    end
    base = wcount;
    send(8'h55, 1'b1);
    nvec++;
    if (wcount !== base) begin
      nerr++;
      $display("FAIL idle_write got %0d writes want 0", wcount - base);
    end
  endtask

  task automatic test_async_reset;
    do_arm(4'd0, 1'b0);
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    rst = 1'b0;
    #1;
    nvec++;
    if ({wr_en, wr_addr, wr_data, busy, triggered, done, trig_addr}
        !== 21'd0) begin
      nerr++;
      $display("FAIL async_rst got %0h want 0",
        {wr_en, wr_addr, wr_data, busy, triggered, done, trig_addr});
    end
    @(negedge clk);
    rst = 1'b1;
    do_arm(4'd0, 1'b0);
    send(8'h33, 1'b1);
    nvec++;
    if (wr_addr !== 4'd0 || trig_addr !== 4'd0 || wr_data !== 8'h33 ||
        busy !== 1'b1) begin
      nerr++;
      $display("FAIL rearm got wa=%0d ta=%0d wd=%0h b=%0b want 0/0/33/1",
        wr_addr, trig_addr, wr_data, busy);
    end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_wait_wrap();
    test_force();
    test_pretrig_max();
    test_control();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
